// File: rtl/alu_ex_stage.sv
// alu_ex_stage: execute stage of the pipelined MIPS datapath.
// Computes the ALU result and zero flag and holds them, along with the
// pass-through control, in a one-entry EX/MEM register. The register sits
// behind a valid/ready handshake with stall and flush support.
// Optional feature: define ALU_EX_OVERFLOW_TRAP_EN to trap signed add/sub
// overflow. A trapped entry sets exc_ovf and suppresses its writes.
module alu_ex_stage #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [4:0]       alu_ctrl,
   input  logic             sign,
   input  logic [WIDTH-1:0] op_a,
   input  logic [WIDTH-1:0] op_b,
   input  logic [4:0]       shamt,
   input  logic [4:0]       wb_addr_i,
   input  logic             reg_write_i,
   input  logic             mem_read_i,
   input  logic             mem_write_i,
   input  logic [WIDTH-1:0] mem_wdata_i,
   input  logic             flush,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] alu_result,
   output logic             zero,
   output logic [4:0]       wb_addr_o,
   output logic             reg_write_o,
   output logic             mem_read_o,
   output logic             mem_write_o,
   output logic [WIDTH-1:0] mem_wdata_o,
   output logic             exc_ovf
);

   localparam logic [WIDTH-1:0] ZERO_W = {WIDTH{1'b0}};

   // ALU function selected by the 5-bit operation code; unused codes give 0.
   function automatic logic [WIDTH-1:0] alu_calc(
      input logic [4:0]       ctrl,
      input logic             sgn,
      input logic [WIDTH-1:0] a,
      input logic [WIDTH-1:0] b,
      input logic [4:0]       sh
   );
      logic [WIDTH-1:0] r;
      logic             lt;
      r  = ZERO_W;
      lt = 1'b0;
      case (ctrl)
         5'd0: r = b;
         5'd1: r = a + b;
         5'd2: r = a - b;
         5'd3: r = a & b;
         5'd4: r = a | b;
         5'd5: r = a ^ b;
         5'd6: r = ~(a | b);
         5'd7: r = b << sh;
         5'd8: begin
            // Kept as if/else: a ternary would force unsigned context and
            // silently turn the arithmetic shift into a logical one.
            if (sgn) begin
               r = $unsigned($signed(b) >>> sh);
            end else begin
               r = b >> sh;
            end
         end
         5'd9: begin
            if (sgn) begin
               lt = ($signed(a) < $signed(b));
            end else begin
               lt = (a < b);
            end
            r = {{(WIDTH-1){1'b0}}, lt};
         end
         default: r = ZERO_W;
      endcase
      return r;
   endfunction

`ifdef ALU_EX_OVERFLOW_TRAP_EN
   // Two's-complement overflow from operand and result sign bits.
   function automatic logic add_sub_ovf(
      input logic is_sub,
      input logic a_msb,
      input logic b_msb,
      input logic r_msb
   );
      logic ovf;
      if (is_sub) begin
         ovf = (a_msb != b_msb) && (r_msb != a_msb);
      end else begin
         ovf = (a_msb == b_msb) && (r_msb != a_msb);
      end
      return ovf;
   endfunction
`endif

   logic [WIDTH-1:0] result_s;
   logic             zero_s;
   logic             trap_s;
   logic             reg_write_s;
   logic             mem_read_s;
   logic             mem_write_s;
   logic             capture_s;

   logic             out_valid_r;
   logic [WIDTH-1:0] result_r;
   logic             zero_r;
   logic [4:0]       wb_addr_r;
   logic             reg_write_r;
   logic             mem_read_r;
   logic             mem_write_r;
   logic [WIDTH-1:0] mem_wdata_r;
   logic             exc_ovf_r;

   assign in_ready  = !out_valid_r || out_ready;
   assign capture_s = in_valid && in_ready && !flush;

   // Next-entry values: ALU result, zero flag and (optionally trapped) control.
   always_comb begin
      result_s = alu_calc(alu_ctrl, sign, op_a, op_b, shamt);
      zero_s   = (result_s == ZERO_W);
`ifdef ALU_EX_OVERFLOW_TRAP_EN
      trap_s = sign && !mem_read_i && !mem_write_i &&
               ((alu_ctrl == 5'd1) || (alu_ctrl == 5'd2)) &&
               add_sub_ovf((alu_ctrl == 5'd2), op_a[WIDTH-1], op_b[WIDTH-1],
                           result_s[WIDTH-1]);
      if (trap_s) begin
         reg_write_s = 1'b0;
         mem_read_s  = 1'b0;
         mem_write_s = 1'b0;
      end else begin
         reg_write_s = reg_write_i;
         mem_read_s  = mem_read_i;
         mem_write_s = mem_write_i;
      end
`else
      trap_s      = 1'b0;
      reg_write_s = reg_write_i;
      mem_read_s  = mem_read_i;
      mem_write_s = mem_write_i;
`endif
   end

   // EX/MEM register: reset, then flush, then capture/consume, then hold.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         out_valid_r <= 1'b0;
         result_r    <= ZERO_W;
         zero_r      <= 1'b0;
         wb_addr_r   <= 5'd0;
         reg_write_r <= 1'b0;
         mem_read_r  <= 1'b0;
         mem_write_r <= 1'b0;
         mem_wdata_r <= ZERO_W;
         exc_ovf_r   <= 1'b0;
      end else if (flush) begin
         out_valid_r <= 1'b0;
      end else if (capture_s) begin
         out_valid_r <= 1'b1;
         result_r    <= result_s;
         zero_r      <= zero_s;
         wb_addr_r   <= wb_addr_i;
         reg_write_r <= reg_write_s;
         mem_read_r  <= mem_read_s;
         mem_write_r <= mem_write_s;
         mem_wdata_r <= mem_wdata_i;
         exc_ovf_r   <= trap_s;
      end else if (out_valid_r && out_ready) begin
         out_valid_r <= 1'b0;
      end else begin
         out_valid_r <= out_valid_r;
      end
   end

   assign out_valid   = out_valid_r;
   assign alu_result  = result_r;
   assign zero        = zero_r;
   assign wb_addr_o   = wb_addr_r;
   assign reg_write_o = reg_write_r;
   assign mem_read_o  = mem_read_r;
   assign mem_write_o = mem_write_r;
   assign mem_wdata_o = mem_wdata_r;
   assign exc_ovf     = exc_ovf_r;

endmodule

// File: tb/tb_alu_ex_stage.sv
// tb_alu_ex_stage: scoreboard bench for alu_ex_stage. Expected entries are
// pushed when an instruction is offered for capture and popped when the
// EX/MEM register presents it.
module tb_alu_ex_stage;

   logic        clk = 1'b0;
   logic        reset;
   logic        in_valid;
   logic        in_ready;
   logic [4:0]  alu_ctrl;
   logic        sign;
   logic [31:0] op_a;
   logic [31:0] op_b;
   logic [4:0]  shamt;
   logic [4:0]  wb_addr_i;
   logic        reg_write_i;
   logic        mem_read_i;
   logic        mem_write_i;
   logic [31:0] mem_wdata_i;
   logic        flush;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] alu_result;
   logic        zero;
   logic [4:0]  wb_addr_o;
   logic        reg_write_o;
   logic        mem_read_o;
   logic        mem_write_o;
   logic [31:0] mem_wdata_o;
   logic        exc_ovf;

   typedef struct packed {
      logic [31:0] res;
      logic        z;
      logic        ovf;
      logic [4:0]  wa;
      logic        rw;
      logic        mr;
      logic        mw;
      logic [31:0] wd;
   } exp_t;

   exp_t sb[$];
   exp_t got;
   exp_t e;
   int   pass_cnt = 0;
   int   total    = 0;

   assign got = {alu_result, zero, exc_ovf, wb_addr_o, reg_write_o,
                 mem_read_o, mem_write_o, mem_wdata_o};

   always #5 clk = ~clk;

   alu_ex_stage #(.WIDTH(32)) dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
      .alu_ctrl(alu_ctrl), .sign(sign), .op_a(op_a), .op_b(op_b),
      .shamt(shamt), .wb_addr_i(wb_addr_i), .reg_write_i(reg_write_i),
      .mem_read_i(mem_read_i), .mem_write_i(mem_write_i),
      .mem_wdata_i(mem_wdata_i), .flush(flush), .out_valid(out_valid),
      .out_ready(out_ready), .alu_result(alu_result), .zero(zero),
      .wb_addr_o(wb_addr_o), .reg_write_o(reg_write_o),
      .mem_read_o(mem_read_o), .mem_write_o(mem_write_o),
      .mem_wdata_o(mem_wdata_o), .exc_ovf(exc_ovf)
   );

   // Reference ALU written independently of the RTL formulation.
   function automatic logic [31:0] model_alu(logic [4:0] c, logic s,
                                             logic [31:0] a, logic [31:0] b,
                                             logic [4:0] sh);
      logic [31:0] r;
      case (c)
         5'd0: r = b;
         5'd1: r = a + b;
         5'd2: r = a + ~b + 32'd1;
         5'd3: r = a & b;
         5'd4: r = a | b;
         5'd5: r = a ^ b;
         5'd6: r = ~(a | b);
         5'd7: r = b << sh;
         5'd8: r = (s && b[31]) ? ~((~b) >> sh) : (b >> sh);
         5'd9: begin
            if (s) r = {31'd0, ((a ^ 32'h8000_0000) < (b ^ 32'h8000_0000))};
            else   r = {31'd0, (a < b)};
         end
         default: r = 32'd0;
      endcase
      return r;
   endfunction

   function automatic exp_t model(logic [4:0] c, logic s, logic [31:0] a,
                                  logic [31:0] b, logic [4:0] sh,
                                  logic [4:0] wa, logic rw, logic mr,
                                  logic mw, logic [31:0] wd);
      exp_t x;
      logic signed [32:0] wide;
      x.res = model_alu(c, s, a, b, sh);
      x.z   = (x.res == 32'd0);
      x.ovf = 1'b0;
      x.wa  = wa;
      x.rw  = rw;
      x.mr  = mr;
      x.mw  = mw;
      x.wd  = wd;
      wide  = 33'sd0;
`ifdef ALU_EX_OVERFLOW_TRAP_EN
      if (s && !mr && !mw && (c == 5'd1 || c == 5'd2)) begin
         if (c == 5'd1) wide = $signed({a[31], a}) + $signed({b[31], b});
         else           wide = $signed({a[31], a}) - $signed({b[31], b});
         if (wide[32] != wide[31]) begin
            x.ovf = 1'b1;
            x.rw  = 1'b0;
            x.mr  = 1'b0;
            x.mw  = 1'b0;
         end
      end
`endif
      return x;
   endfunction

   // Puts an instruction on the ID-side inputs and returns its expectation.
   task automatic drive(input logic [4:0] c, input logic s,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] sh, input logic [4:0] wa,
                        input logic rw, input logic mr, input logic mw,
                        input logic [31:0] wd, output exp_t x);
      alu_ctrl = c; sign = s; op_a = a; op_b = b; shamt = sh;
      wb_addr_i = wa; reg_write_i = rw; mem_read_i = mr; mem_write_i = mw;
      mem_wdata_i = wd; in_valid = 1'b1;
      x = model(c, s, a, b, sh, wa, rw, mr, mw, wd);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      exp_t x;
      out_ready = 1'b0;
      drive(5'd4, 1'b0, 32'h1234_0000, 32'h0000_5678, 5'd0, 5'd9, 1'b1,
            1'b1, 1'b1, 32'hDEAD_BEEF, x);
      tick();
      in_valid = 1'b0;
      total++;
      if (out_valid !== 1'b1) $display("FAIL reset_pre_valid got=%b want=1", out_valid);
      else pass_cnt++;
      reset = 1'b1;
      #2;
      total++;
      if (out_valid !== 1'b0) $display("FAIL reset_async_drop got=%b want=0", out_valid);
      else pass_cnt++;
      tick();
      reset = 1'b0;
      #1;
      total++;
      if (got !== exp_t'(0)) $display("FAIL reset_outputs got=%h want=0", got);
      else pass_cnt++;
      total++;
      if (in_ready !== 1'b1) $display("FAIL reset_in_ready got=%b want=1", in_ready);
      else pass_cnt++;
      out_ready = 1'b1;
   endtask

   typedef struct {
      logic [4:0]  c;
      logic        s;
      logic [31:0] a;
      logic [31:0] b;
      logic [4:0]  sh;
      logic [31:0] res;
   } vec_t;

   task automatic test_ops();
      vec_t v[$];
      exp_t x;
      v = '{
         '{5'd1,  1'b1, 32'hFFFF_FFF0, 32'h0000_0010, 5'd4,  32'h0000_0000},
         '{5'd2,  1'b1, 32'hFFFF_FFF0, 32'h0000_0010, 5'd4,  32'hFFFF_FFE0},
         '{5'd7,  1'b1, 32'hFFFF_FFF0, 32'h0000_0010, 5'd4,  32'h0000_0100},
         '{5'd8,  1'b1, 32'hFFFF_FFF0, 32'h0000_0010, 5'd4,  32'h0000_0001},
         '{5'd9,  1'b1, 32'hFFFF_FFF0, 32'h0000_0010, 5'd4,  32'h0000_0001},
         '{5'd9,  1'b0, 32'hFFFF_FFF0, 32'h0000_0010, 5'd4,  32'h0000_0000},
         '{5'd0,  1'b1, 32'hFFFF_FFF0, 32'h0000_0010, 5'd4,  32'h0000_0010},
         '{5'd3,  1'b1, 32'hFFFF_FFF0, 32'h0000_0010, 5'd4,  32'h0000_0010},
         '{5'd4,  1'b1, 32'hFFFF_FFF0, 32'h0000_0010, 5'd4,  32'hFFFF_FFF0},
         '{5'd5,  1'b1, 32'hFFFF_FFF0, 32'h0000_0010, 5'd4,  32'hFFFF_FFE0},
         '{5'd6,  1'b1, 32'hFFFF_FFF0, 32'h0000_0010, 5'd4,  32'h0000_000F},
         '{5'd15, 1'b1, 32'hFFFF_FFF0, 32'h0000_0010, 5'd4,  32'h0000_0000},
         '{5'd8,  1'b1, 32'h0000_0000, 32'h8000_0000, 5'd31, 32'hFFFF_FFFF},
         '{5'd8,  1'b0, 32'h0000_0000, 32'h8000_0000, 5'd31, 32'h0000_0001}
      };
      out_ready = 1'b1;
      foreach (v[i]) begin
         drive(v[i].c, v[i].s, v[i].a, v[i].b, v[i].sh, 5'd3, 1'b1, 1'b0,
               1'b0, 32'h0, x);
         x.res = v[i].res;
         x.z   = (v[i].res == 32'd0);
         sb.push_back(x);
         tick();
         e = sb.pop_front();
         total++;
         if (out_valid !== 1'b1 || got !== e)
            $display("FAIL op%0d_s%0d got=%h/%b want=%h", v[i].c, v[i].s,
                     alu_result, zero, e.res);
         else pass_cnt++;
      end
      in_valid = 1'b0;
      tick();
   endtask

   task automatic test_stall();
      exp_t x;
      out_ready = 1'b1;
      drive(5'd1, 1'b0, 32'd100, 32'd23, 5'd0, 5'd7, 1'b1, 1'b0, 1'b0,
            32'h0000_00AA, x);
      sb.push_back(x);
      tick();
      out_ready = 1'b0;
      drive(5'd5, 1'b0, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 5'd0, 5'd8, 1'b0,
            1'b0, 1'b1, 32'h0000_00BB, x);
      sb.push_back(x);
      #1;
      for (int k = 0; k < 3; k++) begin
         total++;
         if (in_ready !== 1'b0) $display("FAIL stall_in_ready_c%0d got=%b want=0", k, in_ready);
         else pass_cnt++;
         total++;
         if (out_valid !== 1'b1 || got !== sb[0])
            $display("FAIL stall_frozen_c%0d got=%h want=%h", k, got, sb[0]);
         else pass_cnt++;
         tick();
      end
      out_ready = 1'b1;
      tick();
      in_valid = 1'b0;
      void'(sb.pop_front());
      e = sb.pop_front();
      total++;
      if (out_valid !== 1'b1 || got !== e) $display("FAIL stall_next got=%h want=%h", got, e);
      else pass_cnt++;
      tick();
      total++;
      if (out_valid !== 1'b0) $display("FAIL stall_no_dup got=%b want=0", out_valid);
      else pass_cnt++;
   endtask

   task automatic test_flush();
      exp_t x;
      out_ready = 1'b0;
      drive(5'd0, 1'b0, 32'd0, 32'h0000_0042, 5'd0, 5'd1, 1'b1, 1'b0, 1'b0,
            32'd0, x);
      tick();
      total++;
      if (out_valid !== 1'b1 || got !== x) $display("FAIL flush_setup got=%h want=%h", got, x);
      else pass_cnt++;
      drive(5'd4, 1'b0, 32'h1111_0000, 32'h0000_2222, 5'd0, 5'd2, 1'b1,
            1'b0, 1'b0, 32'd0, x);
      flush = 1'b1;
      tick();
      flush = 1'b0;
      in_valid = 1'b0;
      out_ready = 1'b1;
      total++;
      if (out_valid !== 1'b0) $display("FAIL flush_kill got=%b want=0", out_valid);
      else pass_cnt++;
      tick();
      total++;
      if (out_valid !== 1'b0) $display("FAIL flush_discard got=%b want=0", out_valid);
      else pass_cnt++;
   endtask

   task automatic test_overflow();
      exp_t x;
      out_ready = 1'b1;
      drive(5'd1, 1'b1, 32'h7FFF_FFFF, 32'h0000_0001, 5'd0, 5'd4, 1'b1,
            1'b0, 1'b0, 32'd0, x);
      sb.push_back(x);
      tick();
      e = sb.pop_front();
      total++;
      if (got !== e) $display("FAIL ovf_signed got=%h want=%h", got, e);
      else pass_cnt++;
      total++;
      if (alu_result !== 32'h8000_0000) $display("FAIL ovf_wrap got=%h want=80000000", alu_result);
      else pass_cnt++;
`ifdef ALU_EX_OVERFLOW_TRAP_EN
      total++;
      if (exc_ovf !== 1'b1 || reg_write_o !== 1'b0)
         $display("FAIL ovf_trap got=%b/%b want=1/0", exc_ovf, reg_write_o);
      else pass_cnt++;
`else
      total++;
      if (exc_ovf !== 1'b0 || reg_write_o !== 1'b1)
         $display("FAIL ovf_notrap got=%b/%b want=0/1", exc_ovf, reg_write_o);
      else pass_cnt++;
`endif
      drive(5'd1, 1'b0, 32'h7FFF_FFFF, 32'h0000_0001, 5'd0, 5'd4, 1'b1,
            1'b0, 1'b0, 32'd0, x);
      tick();
      in_valid = 1'b0;
      total++;
      if (exc_ovf !== 1'b0 || reg_write_o !== 1'b1)
         $display("FAIL ovf_unsigned got=%b/%b want=0/1", exc_ovf, reg_write_o);
      else pass_cnt++;
   endtask

   task automatic test_back_to_back();
      exp_t x;
      out_ready = 1'b1;
      for (int i = 0; i < 24; i++) begin
         drive(5'($urandom_range(0, 12)), 1'($urandom), $urandom, $urandom,
               5'($urandom), 5'($urandom), 1'($urandom), 1'($urandom),
               1'($urandom), $urandom, x);
         sb.push_back(x);
         tick();
         e = sb.pop_front();
         total++;
         if (out_valid !== 1'b1 || got !== e)
            $display("FAIL b2b_%0d got=%h want=%h", i, got, e);
         else pass_cnt++;
      end
      in_valid = 1'b0;
      tick();
      total++;
      if (out_valid !== 1'b0) $display("FAIL b2b_drain got=%b want=0", out_valid);
      else pass_cnt++;
   endtask

   initial begin
      reset = 1'b1; in_valid = 1'b0; alu_ctrl = 5'd0; sign = 1'b0;
      op_a = 32'd0; op_b = 32'd0; shamt = 5'd0; wb_addr_i = 5'd0;
      reg_write_i = 1'b0; mem_read_i = 1'b0; mem_write_i = 1'b0;
      mem_wdata_i = 32'd0; flush = 1'b0; out_ready = 1'b1;
      tick();
      tick();
      reset = 1'b0;
      tick();
      test_reset();
      test_ops();
      test_stall();
      test_flush();
      test_overflow();
      test_back_to_back();
      $display("%0d/%0d checks passed", pass_cnt, total);
      $finish;
   end

endmodule
